// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: write-source codes and the
// tracked-writer entry.
package fwd_pkg;

   typedef enum logic [2:0] {
      WS_MEM   = 3'd0,
      WS_ALU   = 3'd1,
      WS_SP    = 3'd2,
      WS_INPUT = 3'd3,
      WS_IMM   = 3'd4
   } wsrc_e;

   // Operand mux select meaning "read the register file, no forward".
   localparam logic [2:0] SEL_REGFILE = 3'd2;

   // Entry address field is fixed-width so the struct is parameter-independent;
   // register addresses are zero-extended into it (supports up to 256 registers).
   localparam int ENT_AW = 8;

   typedef struct packed {
      logic              valid;
      logic [ENT_AW-1:0] waddr;
      wsrc_e             wsrc;
   } entry_t;

endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode-side bus of the forwarding scoreboard: issue, source reads, pipeline
// controls and the per-port forward selects.
interface forward_scoreboard_if #(
   parameter int NUM_REGS  = 4,
   parameter int NUM_PORTS = 2,
   parameter int DEPTH     = 2
);
   localparam int REG_AW = $clog2(NUM_REGS);
   localparam int STG_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                                 issue_valid;
   logic                                 issue_we;
   logic [REG_AW-1:0]                    issue_waddr;
   logic [2:0]                           issue_wsrc;
   logic [NUM_PORTS-1:0]                 rd_en;
   logic [NUM_PORTS-1:0][REG_AW-1:0]     rd_addr;
   logic                                 freeze;
   logic                                 flush;
   logic [NUM_PORTS-1:0][2:0]            fwd_src;
   logic [NUM_PORTS-1:0][STG_W-1:0]      fwd_stage;
   logic                                 load_use_stall;
   logic [15:0]                          stall_count;

   modport master (
      output issue_valid, issue_we, issue_waddr, issue_wsrc,
      output rd_en, rd_addr, freeze, flush,
      input  fwd_src, fwd_stage, load_use_stall, stall_count
   );

   modport slave (
      input  issue_valid, issue_we, issue_waddr, issue_wsrc,
      input  rd_en, rd_addr, freeze, flush,
      output fwd_src, fwd_stage, load_use_stall, stall_count
   );

endinterface

// File: rtl/fwd_port_match.sv
// One source read port: finds the youngest in-flight writer of its register
// and reports its write source and stage index.
module fwd_port_match
   import fwd_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int STG_W    = 1,
   parameter int REG_AW   = 2,
   parameter int EXCL_REG = 3
) (
   input  logic                 rd_en_i,
   input  logic [REG_AW-1:0]    rd_addr_i,
   input  entry_t [DEPTH-1:0]   ent_i,
   output logic [2:0]           src_o,
   output logic [STG_W-1:0]     stage_o,
   output logic                 ld_hit_o
);

   logic addr_ok;

   assign addr_ok = rd_en_i && (rd_addr_i != REG_AW'(EXCL_REG));

   // Scan oldest to youngest so the lowest-index match is the one that sticks.
   always_comb begin
      src_o   = SEL_REGFILE;
      stage_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (addr_ok && ent_i[i].valid && (ent_i[i].wsrc != WS_SP) &&
             (ent_i[i].waddr == ENT_AW'(rd_addr_i))) begin
            src_o   = ent_i[i].wsrc;
            stage_o = STG_W'(i);
         end
      end
   end

   // Only the immediately preceding instruction can cause a load-use hazard.
   assign ld_hit_o = (src_o == WS_MEM) && (stage_o == '0);

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight register writers and drives operand-forward selects and the
// load-use stall for the decode stage.
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_REGS  = 4,
   parameter int NUM_PORTS = 2,
   parameter int DEPTH     = 2,
   parameter int EXCL_REG  = NUM_REGS - 1
) (
   input  logic                   clk,
   input  logic                   rst,
   forward_scoreboard_if.slave    bus
);

   localparam int REG_AW = $clog2(NUM_REGS);
   localparam int STG_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t [DEPTH-1:0]               ent_q, ent_d;
   logic [15:0]                      cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]             ld_hit;
   logic [NUM_PORTS-1:0][2:0]        src;
   logic [NUM_PORTS-1:0][STG_W-1:0]  stage;
   logic                             stall;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      fwd_port_match #(
         .DEPTH    (DEPTH),
         .STG_W    (STG_W),
         .REG_AW   (REG_AW),
         .EXCL_REG (EXCL_REG)
      ) u_match (
         .rd_en_i   (bus.rd_en[p]),
         .rd_addr_i (bus.rd_addr[p]),
         .ent_i     (ent_q),
         .src_o     (src[p]),
         .stage_o   (stage[p]),
         .ld_hit_o  (ld_hit[p])
      );
   end

   assign stall              = (|ld_hit) && !bus.freeze;
   assign bus.fwd_src        = src;
   assign bus.fwd_stage      = stage;
   assign bus.load_use_stall = stall;
   assign bus.stall_count    = cnt_q;

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (stall && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].valid = 1'b0;
         end
      end else if (!bus.freeze) begin
         for (int i = 1; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
         end
         // A stalled decode inserts a bubble; the held instruction re-issues later.
         if (stall) begin
            ent_d[0] = '0;
         end else begin
            ent_d[0].valid = bus.issue_valid && bus.issue_we;
            ent_d[0].waddr = ENT_AW'(bus.issue_waddr);
            ent_d[0].wsrc  = wsrc_e'(bus.issue_wsrc);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a queue model
// of in-flight writers; a negedge monitor pops and compares.
module tb_forward_scoreboard;

   localparam int NR   = 4;
   localparam int NP   = 2;
   localparam int D    = 2;
   localparam int EXCL = NR - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   forward_scoreboard_if #(.NUM_REGS(NR), .NUM_PORTS(NP), .DEPTH(D)) bus ();

   forward_scoreboard #(.NUM_REGS(NR), .NUM_PORTS(NP), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit v;
      int addr;
      int src;
   } wr_t;

   typedef struct {
      int src0;
      int src1;
      int stg0;
      int stg1;
      bit stall;
      int cnt;
   } exp_t;

   wr_t  hist[$];     // front = most recent writer
   int   m_cnt;
   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(string name, int act, int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Youngest writer of register a that may be forwarded, if any.
   function automatic void port_exp(bit en, int a, output int s, output int g);
      s = 2;
      g = 0;
      if (en && a != EXCL) begin
         for (int i = 0; i < D; i++) begin
            if (hist[i].v && hist[i].addr == a && hist[i].src != 2) begin
               s = hist[i].src;
               g = i;
               break;
            end
         end
      end
   endfunction

   // Load-use hazard: the previous instruction is a load into this source.
   function automatic bit load_use(bit en, int a);
      return en && a != EXCL && hist[0].v && hist[0].addr == a && hist[0].src == 0;
   endfunction

   task automatic cyc(bit iv, bit we, int wa, int ws, bit [1:0] en, int a0, int a1,
                      bit frz, bit fl, bit r, bit check = 1'b1);
      exp_t e;
      bit   st;
      wr_t  w;
      bus.issue_valid = iv;
      bus.issue_we    = we;
      bus.issue_waddr = 2'(wa);
      bus.issue_wsrc  = 3'(ws);
      bus.rd_en       = en;
      bus.rd_addr[0]  = 2'(a0);
      bus.rd_addr[1]  = 2'(a1);
      bus.freeze      = frz;
      bus.flush       = fl;
      rst             = r;
      port_exp(en[0], a0, e.src0, e.stg0);
      port_exp(en[1], a1, e.src1, e.stg1);
      st      = !frz && (load_use(en[0], a0) || load_use(en[1], a1));
      e.stall = st;
      e.cnt   = m_cnt;
      if (check) exp_q.push_back(e);
      if (r) begin
         foreach (hist[i]) hist[i].v = 1'b0;
         m_cnt = 0;
      end else begin
         if (st && m_cnt < 65535) m_cnt++;
         if (fl) begin
            foreach (hist[i]) hist[i].v = 1'b0;
         end else if (!frz) begin
            w.v    = st ? 1'b0 : (iv && we);
            w.addr = wa;
            w.src  = ws;
            hist.push_front(w);
            void'(hist.pop_back());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(bit [1:0] en, int a0, int a1);
      cyc(1'b0, 1'b0, 0, 0, en, a0, a1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr(int wa, int ws);
      cyc(1'b1, 1'b1, wa, ws, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwd_src0",    int'(bus.fwd_src[0]),      e.src0);
            chk("fwd_src1",    int'(bus.fwd_src[1]),      e.src1);
            chk("fwd_stage0",  int'(bus.fwd_stage[0]),    e.stg0);
            chk("fwd_stage1",  int'(bus.fwd_stage[1]),    e.stg1);
            chk("stall",       int'(bus.load_use_stall),  int'(e.stall));
            chk("stall_count", int'(bus.stall_count),     e.cnt);
         end
      end
   end

   initial begin : driver
      for (int i = 0; i < D; i++) hist.push_back('{v: 1'b0, addr: 0, src: 0});
      m_cnt = 0;
      cyc(1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      rd(2'b11, 1, 2);                    // post-reset defaults

      wr(1, 1);  rd(2'b01, 1, 0);  rd(2'b01, 1, 0);         // ALU forward, stage 0 then 1
      wr(1, 0);  rd(2'b10, 0, 1);  rd(2'b10, 0, 1);         // load-use stall then MEM fwd
      wr(2, 3);  wr(2, 4);  rd(2'b11, 2, 2);                // youngest wins
      wr(3, 1);  rd(2'b11, 3, 3);                           // excluded register
      wr(1, 2);  rd(2'b11, 1, 1);                           // SP-sourced write

      wr(0, 1);  wr(1, 1);
      cyc(1'b1, 1'b1, 2, 1, 2'b11, 0, 1, 1'b0, 1'b1, 1'b0); // flush with issue
      rd(2'b11, 0, 1);

      wr(0, 1);  wr(1, 0);
      repeat (3) cyc(1'b1, 1'b1, 2, 4, 2'b11, 0, 1, 1'b1, 1'b0, 1'b0);
      rd(2'b11, 0, 1);  rd(2'b11, 0, 1);

      wr(2, 0);
      cyc(1'b0, 1'b0, 0, 0, 2'b01, 2, 0, 1'b0, 1'b0, 1'b1); // reset during stall
      rd(2'b11, 2, 2);

      repeat (400) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
             2'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 63) == 0));
      end

      // Counter saturation: one load-use stall every other cycle.
      cyc(1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
      repeat (65540) begin
         wr(1, 0);
         rd(2'b01, 1, 0);
      end
      rd(2'b11, 1, 1);

      @(negedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
